// File: rtl/data_mem_access_pkg.sv
// Shared constants and state encoding for the data-memory access stage.
// Imported by the interface, the stage and the bench.
package data_mem_access_pkg;

    localparam int WORD_W   = 32;
    localparam int BYTE_OFF = 2;
    localparam int MADDR_W  = WORD_W - BYTE_OFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/data_mem_access_if.sv
// CPU request/response and RAM-side bundle of the memory-access stage.
// The slave modport is the stage; the master side is the pipeline plus RAM.
interface data_mem_access_if;
    import data_mem_access_pkg::*;

    logic              Req_Valid;
    logic              Req_Ready;
    logic              Req_Write;
    logic [WORD_W-1:0] Req_Addr;
    logic [WORD_W-1:0] Req_Data;
    logic              Rsp_Valid;
    logic              Rsp_Ready;
    logic [WORD_W-1:0] Rsp_Data;
    logic              Rsp_Fault;
    logic [MADDR_W-1:0] Mem_Addr;
    logic              Mem_En_R;
    logic              Mem_En_W;
    logic [WORD_W-1:0] Mem_Data_W;
    logic [WORD_W-1:0] Mem_Data_R;

    modport slave (
        input  Req_Valid, Req_Write, Req_Addr, Req_Data,
        input  Rsp_Ready, Mem_Data_R,
        output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Fault,
        output Mem_Addr, Mem_En_R, Mem_En_W, Mem_Data_W
    );

    modport master (
        output Req_Valid, Req_Write, Req_Addr, Req_Data,
        output Rsp_Ready, Mem_Data_R,
        input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Fault,
        input  Mem_Addr, Mem_En_R, Mem_En_W, Mem_Data_W
    );

endinterface

// File: rtl/data_mem_access.sv
// Load/store stage in front of the data RAM: checks alignment and range,
// pulses one RAM enable per request and holds the response until taken.
module data_mem_access
    import data_mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int MEM_AW    = 10
) (
    input  logic Clock,
    input  logic Reset_N,
    data_mem_access_if.slave bus
);

    localparam logic [WORD_W:0] LIMIT = (WORD_W+1)'(MEM_WORDS * 4);

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic                fault_q, fault_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;

    function automatic logic is_fault(input logic [WORD_W-1:0] a);
        return (a[BYTE_OFF-1:0] != '0) || ({1'b0, a} >= LIMIT);
    endfunction

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            fault_q <= fault_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        fault_d = fault_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Req_Valid) begin
                    wr_d    = bus.Req_Write;
                    rdata_d = '0;
                    if (is_fault(bus.Req_Addr)) begin
                        // RAM-side registers keep their last value on a fault
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        fault_d = 1'b0;
                        addr_d  = bus.Req_Addr[BYTE_OFF +: MEM_AW];
                        wdata_d = bus.Req_Data;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = wr_q ? RESP : WAIT;
            WAIT: begin
                rdata_d = bus.Mem_Data_R;
                state_d = RESP;
            end
            RESP: begin
                if (bus.Rsp_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.Req_Ready  = (state_q == IDLE);
    assign bus.Rsp_Valid  = (state_q == RESP);
    assign bus.Rsp_Data   = rdata_q;
    assign bus.Rsp_Fault  = fault_q;
    assign bus.Mem_Addr   = {{(MADDR_W-MEM_AW){1'b0}}, addr_q};
    assign bus.Mem_En_R   = (state_q == ISSUE) && !wr_q;
    assign bus.Mem_En_W   = (state_q == ISSUE) && wr_q;
    assign bus.Mem_Data_W = wdata_q;

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: directed table, hold/reset sequences and a
// random load/store mix checked against a word-array reference model.
module tb_data_mem_access;
    import data_mem_access_pkg::*;

    localparam int NW = 1024;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    data_mem_access_if bus();

    data_mem_access #(.MEM_WORDS(NW), .MEM_AW(10)) dut (
        .Clock  (clk),
        .Reset_N(rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [0:NW-1];
    logic [31:0] ref_mem [0:NW-1];

    always @(posedge clk) begin
        if (bus.Mem_En_W) ram[bus.Mem_Addr[9:0]] <= bus.Mem_Data_W;
        if (bus.Mem_En_R) bus.Mem_Data_R <= ram[bus.Mem_Addr[9:0]];
    end

    always @(negedge clk) begin
        checks++;
        if (bus.Mem_En_R && bus.Mem_En_W) begin
            errors++;
            $display("FAIL both_en: En_R=1 En_W=1 required at most one");
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Starts and ends at a negedge; hold = extra RESP cycles with Rsp_Ready=0.
    task automatic do_req(input bit w, input logic [31:0] a,
                          input logic [31:0] d, input bit ef,
                          input logic [31:0] ed, input int el,
                          input int hold, input bit pend);
        int n;
        int lat;
        int nr;
        int nw;
        logic [31:0] sa;
        logic [31:0] sd;
        n = 0; lat = 0; nr = 0; nw = 0; sa = '0; sd = '0;
        bus.Req_Valid = 1'b1;
        bus.Req_Write = w;
        bus.Req_Addr  = a;
        bus.Req_Data  = d;
        bus.Rsp_Ready = 1'b0;
        while (!bus.Req_Ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 32'(n < 20), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.Req_Valid = 1'b0;
            if (bus.Mem_En_R) nr++;
            if (bus.Mem_En_W) nw++;
            if (bus.Mem_En_R || bus.Mem_En_W) begin
                sa = 32'(bus.Mem_Addr);
                sd = bus.Mem_Data_W;
            end
            if (bus.Rsp_Valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(el));
        chk("rsp_fault", 32'(bus.Rsp_Fault), 32'(ef));
        chk("rsp_data", bus.Rsp_Data, ed);
        chk("en_r_count", 32'(nr), 32'(!w && !ef));
        chk("en_w_count", 32'(nw), 32'(w && !ef));
        if (nr + nw > 0) chk("mem_addr", sa, a >> 2);
        if (nw > 0) chk("mem_wdata", sd, d);
        for (int h = 0; h < hold; h++) begin
            if (pend && h == 0) begin
                bus.Req_Valid = 1'b1;
                bus.Req_Write = 1'b1;
                bus.Req_Addr  = 32'h0000_0040;
                bus.Req_Data  = 32'h1234_5678;
            end
            @(negedge clk);
            chk("hold_valid", 32'(bus.Rsp_Valid), 32'd1);
            chk("hold_data", bus.Rsp_Data, ed);
            chk("hold_ready", 32'(bus.Req_Ready), 32'd0);
            chk("hold_no_en", 32'(bus.Mem_En_R | bus.Mem_En_W), 32'd0);
        end
        bus.Rsp_Ready = 1'b1;
        @(negedge clk);
        bus.Rsp_Ready = 1'b0;
        chk("release_valid", 32'(bus.Rsp_Valid), 32'd0);
        chk("release_ready", 32'(bus.Req_Ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.Req_Ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.Rsp_Valid), 32'd0);
        chk({tag, "_rsp_data"}, bus.Rsp_Data, 32'd0);
        chk({tag, "_rsp_fault"}, 32'(bus.Rsp_Fault), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.Mem_Addr), 32'd0);
        chk({tag, "_en"}, 32'(bus.Mem_En_R | bus.Mem_En_W), 32'd0);
        chk({tag, "_mem_wdata"}, bus.Mem_Data_W, 32'd0);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        bit          f;
        logic [31:0] ed;
        int          lat;
    } vec_t;

    vec_t vt [8];

    function automatic bit model_fault(input logic [31:0] a);
        return (a % 4 != 0) || (64'(a) >= 64'(NW * 4));
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ed;
        bit          w;
        bit          f;
        int          r;

        vt[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 2};
        vt[1] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 3};
        vt[2] = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'h0, 1};
        vt[3] = '{1'b1, 32'h0000_1000, 32'h5555_AAAA, 1'b1, 32'h0, 1};
        vt[4] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0, 2};
        vt[5] = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D, 3};
        vt[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0, 1};
        vt[7] = '{1'b1, 32'h0000_0002, 32'h0BAD_0BAD, 1'b1, 32'h0, 1};

        checks = 0;
        errors = 0;
        for (int i = 0; i < NW; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        bus.Req_Valid  = 1'b0;
        bus.Req_Write  = 1'b0;
        bus.Req_Addr   = '0;
        bus.Req_Data   = '0;
        bus.Rsp_Ready  = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            do_req(vt[i].w, vt[i].a, vt[i].d, vt[i].f, vt[i].ed,
                   vt[i].lat, 0, 1'b0);
            if (vt[i].w && !vt[i].f) ref_mem[vt[i].a / 4] = vt[i].d;
        end

        // stall response for 5 cycles with a store waiting behind it
        do_req(1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 3, 5, 1'b1);
        do_req(1'b1, 32'h40, 32'h1234_5678, 1'b0, 32'h0, 2, 0, 1'b0);
        ref_mem[16] = 32'h1234_5678;
        do_req(1'b0, 32'h40, 32'h0, 1'b0, 32'h1234_5678, 3, 0, 1'b0);

        // reset while a load sits in WAIT
        bus.Req_Valid = 1'b1;
        bus.Req_Write = 1'b0;
        bus.Req_Addr  = 32'h40;
        @(posedge clk);
        @(negedge clk);
        bus.Req_Valid = 1'b0;
        chk("mid_issue_en_r", 32'(bus.Mem_En_R), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(bus.Rsp_Valid), 32'd0);
        end
        do_req(1'b0, 32'h40, 32'h0, 1'b0, ref_mem[16], 3, 0, 1'b0);

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = 32'($urandom_range(0, 31)) * 4;
            else if (r == 7) a = 32'($urandom_range(0, 31)) * 4
                                 + 32'($urandom_range(1, 3));
            else if (r == 8) a = 32'(NW * 4) + 32'($urandom_range(0, 999)) * 4;
            else             a = $urandom | 32'h8000_0000;
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            f = model_fault(a);
            ed = (f || w) ? 32'h0 : ref_mem[a / 4];
            do_req(w, a, d, f, ed, f ? 1 : (w ? 2 : 3),
                   int'($urandom_range(0, 2)), 1'b0);
            if (!f && w) ref_mem[a / 4] = d;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
